// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encodings, column pattern,
// key code width and small decode helpers.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [3:0]  COL_RESET  = 4'b1110;
  localparam int unsigned KEY_CODE_W = 4;

  // Index of the strobed (low) column in a one-hot-low pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Lowest-numbered low row; scanning downwards lets the lowest index win.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!rows_n[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key FIFO read port: head code plus valid/ready handshake toward the processor.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// Small key FIFO: extra pointer bit distinguishes full from empty; drops on full
// and latches a sticky overflow flag.
module keypad_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign valid = !empty;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, synchronizes and debounces rows,
// and queues one key code per debounced press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  keypad_scanner_if.master  key_if,
  output logic              key_held,
  output logic              overflow
);

  localparam int unsigned     DEB_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]            row_meta;
  logic [3:0]            row_sync;
  logic [DIV_W-1:0]      dwell;
  logic                  tick;
  scan_state_e           state;
  logic [DEB_W-1:0]      deb;
  logic [1:0]            cand_row;
  logic [KEY_CODE_W-1:0] cand_code;
  logic                  cand_low;
  logic                  push;
  logic [3:0]            col_rot;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
      dwell    <= '0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      dwell    <= dwell + 1'b1;
    end
  end

  assign tick     = &dwell;
  assign cand_low = !row_sync[cand_row];
  assign col_rot  = {col_n[2:0], col_n[3]};
  // The push is taken on the same edge that moves the FSM into HELD.
  assign push     = tick && (state == DEBOUNCE) && cand_low && (deb == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col_n     <= COL_RESET;
      deb       <= '0;
      cand_row  <= '0;
      cand_code <= '0;
      key_held  <= 1'b0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (row_sync != 4'b1111) begin
            cand_row  <= lowest_low(row_sync);
            cand_code <= {lowest_low(row_sync), col_index(col_n)};
            deb       <= DEB_ONE;
            state     <= DEBOUNCE;
          end else begin
            col_n <= col_rot;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            if (deb == DEB_LAST) begin
              key_held <= 1'b1;
              state    <= HELD;
            end else begin
              deb <= deb + DEB_ONE;
            end
          end else begin
            col_n <= col_rot;
            state <= SCAN;
          end
        end
        HELD: begin
          if (!cand_low) begin
            deb   <= DEB_ONE;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            if (deb == DEB_LAST) begin
              key_held <= 1'b0;
              col_n    <= col_rot;
              state    <= SCAN;
            end else begin
              deb <= deb + DEB_ONE;
            end
          end else begin
            state <= HELD;
          end
        end
      endcase
    end
  end

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cand_code),
    .pop       (key_if.key_ready),
    .head      (key_if.key_code),
    .valid     (key_if.key_valid),
    .overflow  (overflow)
  );

endmodule
